// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encoding and
// datapath widths used by the controller and its event counters.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1
    } state_e;

    localparam int CNT_W = 32;
    localparam int PC_W  = 32;
    localparam int REG_W = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_cnt32.sv
// Saturating event counter with synchronous clear; clear beats increment and
// the count sticks at all-ones instead of wrapping.
module sat_cnt32
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, EX-stage redirect with a
// pending state while the icache is busy, and stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_jump,
    input  logic             ex_branch_valid,
    input  logic             ex_mispredict,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             dcache_stall,
    input  logic             icache_stall,
    input  logic             cnt_clr,
    output logic             stall_back,
    output logic             stall_front,
    output logic             bubble_ex,
    output logic             flush_front,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            load_use;
    logic            redir_evt;
    logic            flush_inc;

    assign load_use = ex_valid & ex_memrd & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    // A redirect computed while the dcache holds EX is not yet committed.
    assign redir_evt = ex_valid & ~dcache_stall &
                       (ex_jump | (ex_branch_valid & ex_mispredict));

    always_comb begin
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;
        stall_back     = 1'b0;
        stall_front    = 1'b0;
        bubble_ex      = 1'b0;
        flush_front    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush_inc      = 1'b0;
        if (!rst) begin
            stall_back = dcache_stall;
            case (state_q)
                ST_RUN: begin
                    if (dcache_stall) begin
                        stall_front = 1'b1;
                    end else if (redir_evt) begin
                        flush_front = 1'b1;
                        flush_inc   = 1'b1;
                        if (!icache_stall) begin
                            redirect_valid = 1'b1;
                            redirect_pc    = ex_target;
                        end else begin
                            pend_pc_d = ex_target;
                            state_d   = ST_PEND;
                        end
                    end else if (load_use) begin
                        stall_front = 1'b1;
                        bubble_ex   = 1'b1;
                    end
                end
                ST_PEND: begin
                    stall_front = dcache_stall;
                    flush_front = 1'b1;
                    if (!icache_stall) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = pend_pc_q;
                        state_d        = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign state = rst ? 2'b00 : state_q;

    sat_cnt32 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (stall_front),
        .cnt_o (stall_cnt)
    );

    sat_cnt32 u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cycles push hand-computed
// expectations; a negedge monitor pops and compares every presented cycle.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic        ex_valid, ex_memrd;
    logic [4:0]  ex_rd;
    logic        ex_jump, ex_branch_valid, ex_mispredict;
    logic [31:0] ex_target;
    logic        dcache_stall, icache_stall, cnt_clr;
    logic        stall_back, stall_front, bubble_ex, flush_front, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          tag;
        logic        sb, sf, bx, ff, rv;
        logic [31:0] rpc;
        logic [1:0]  st;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t sb_q[$];

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_valid        (ex_valid),
        .ex_memrd        (ex_memrd),
        .ex_rd           (ex_rd),
        .ex_jump         (ex_jump),
        .ex_branch_valid (ex_branch_valid),
        .ex_mispredict   (ex_mispredict),
        .ex_target       (ex_target),
        .dcache_stall    (dcache_stall),
        .icache_stall    (icache_stall),
        .cnt_clr         (cnt_clr),
        .stall_back      (stall_back),
        .stall_front     (stall_front),
        .bubble_ex       (bubble_ex),
        .flush_front     (flush_front),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, tag, act, exp_v);
        end
    endtask

    task automatic expect_out(input int tag, input logic sb, input logic sf, input logic bx,
                              input logic ff, input logic rv, input logic [31:0] rpc,
                              input logic [1:0] st, input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e.tag = tag; e.sb = sb; e.sf = sf; e.bx = bx; e.ff = ff; e.rv = rv;
        e.rpc = rpc; e.st = st; e.sc = sc; e.fc = fc;
        sb_q.push_back(e);
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_valid = 1'b0; ex_memrd = 1'b0; ex_rd = '0;
        ex_jump = 1'b0; ex_branch_valid = 1'b0; ex_mispredict = 1'b0;
        ex_target = '0; dcache_stall = 1'b0; icache_stall = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_valid = 1'b1; ex_memrd = 1'b1; ex_rd = rd;
        id_rs1 = rd; id_use_rs1 = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stall_back",     e.tag, 32'(stall_back),     32'(e.sb));
            chk("stall_front",    e.tag, 32'(stall_front),    32'(e.sf));
            chk("bubble_ex",      e.tag, 32'(bubble_ex),      32'(e.bx));
            chk("flush_front",    e.tag, 32'(flush_front),    32'(e.ff));
            chk("redirect_valid", e.tag, 32'(redirect_valid), 32'(e.rv));
            chk("redirect_pc",    e.tag, redirect_pc,         e.rpc);
            chk("state",          e.tag, 32'(state),          32'(e.st));
            chk("stall_cnt",      e.tag, stall_cnt,           e.sc);
            chk("flush_cnt",      e.tag, flush_cnt,           e.fc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_valid = 1'b0; ex_memrd = 1'b0; ex_rd = '0;
        ex_jump = 1'b0; ex_branch_valid = 1'b0; ex_mispredict = 1'b0;
        ex_target = '0; dcache_stall = 1'b0; icache_stall = 1'b0; cnt_clr = 1'b0;

        // Reset with active events: all control outputs held low.
        next_cycle(); rst = 1'b1; dcache_stall = 1'b1; ex_valid = 1'b1; ex_jump = 1'b1;
        ex_target = 32'h44; set_load_use(5'd3);
        expect_out(0, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd0, 32'd0);
        next_cycle();
        expect_out(1, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd0, 32'd0);

        // Load-use on rs1: one bubble, counted once.
        next_cycle(); set_load_use(5'd5);
        expect_out(2, 0, 1, 1, 0, 0, 32'h0, 2'd0, 32'd0, 32'd0);
        next_cycle();
        expect_out(3, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd1, 32'd0);
        // Load to x0 is never a hazard.
        next_cycle(); set_load_use(5'd0);
        expect_out(4, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd1, 32'd0);
        // rs2 match counts; an unused rs1 match does not.
        next_cycle(); ex_valid = 1'b1; ex_memrd = 1'b1; ex_rd = 5'd7;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        expect_out(5, 0, 1, 1, 0, 0, 32'h0, 2'd0, 32'd1, 32'd0);
        next_cycle(); ex_valid = 1'b1; ex_memrd = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        expect_out(6, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd2, 32'd0);

        // Mispredict with idle icache: same-cycle redirect.
        next_cycle(); ex_valid = 1'b1; ex_branch_valid = 1'b1; ex_mispredict = 1'b1;
        ex_target = 32'h100;
        expect_out(7, 0, 0, 0, 1, 1, 32'h100, 2'd0, 32'd2, 32'd0);
        // Correctly predicted branch and an invalid jump do nothing.
        next_cycle(); ex_valid = 1'b1; ex_branch_valid = 1'b1; ex_target = 32'h200;
        expect_out(8, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd2, 32'd1);
        next_cycle(); ex_jump = 1'b1; ex_target = 32'h204;
        expect_out(9, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd2, 32'd1);

        // Jump with icache busy: three pending cycles, then redirect.
        next_cycle(); ex_valid = 1'b1; ex_jump = 1'b1; ex_target = 32'h2A4; icache_stall = 1'b1;
        expect_out(10, 0, 0, 0, 1, 0, 32'h0, 2'd0, 32'd2, 32'd1);
        next_cycle(); icache_stall = 1'b1;
        expect_out(11, 0, 0, 0, 1, 0, 32'h0, 2'd1, 32'd2, 32'd2);
        next_cycle(); icache_stall = 1'b1; ex_jump = 1'b1; ex_target = 32'h999;
        ex_memrd = 1'b1; ex_valid = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        expect_out(12, 0, 0, 0, 1, 0, 32'h0, 2'd1, 32'd2, 32'd2);
        next_cycle(); icache_stall = 1'b1; dcache_stall = 1'b1;
        expect_out(13, 1, 1, 0, 1, 0, 32'h0, 2'd1, 32'd2, 32'd2);
        next_cycle();
        expect_out(14, 0, 0, 0, 1, 1, 32'h2A4, 2'd1, 32'd3, 32'd2);
        next_cycle();
        expect_out(15, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd3, 32'd2);

        // dcache stall beats mispredict and load-use; redirect follows the stall.
        next_cycle(); dcache_stall = 1'b1; ex_branch_valid = 1'b1; ex_mispredict = 1'b1;
        ex_target = 32'h300; set_load_use(5'd5);
        expect_out(16, 1, 1, 0, 0, 0, 32'h0, 2'd0, 32'd3, 32'd2);
        next_cycle(); ex_branch_valid = 1'b1; ex_mispredict = 1'b1;
        ex_target = 32'h300; set_load_use(5'd5);
        expect_out(17, 0, 0, 0, 1, 1, 32'h300, 2'd0, 32'd4, 32'd2);

        // Clear wins over a simultaneous increment.
        next_cycle(); cnt_clr = 1'b1; set_load_use(5'd6);
        expect_out(18, 0, 1, 1, 0, 0, 32'h0, 2'd0, 32'd4, 32'd3);
        next_cycle();
        expect_out(19, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd0, 32'd0);

        // Saturation from a preloaded near-full stall count.
        next_cycle();
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        dcache_stall = 1'b1;
        expect_out(20, 1, 1, 0, 0, 0, 32'h0, 2'd0, 32'hFFFF_FFFE, 32'd0);
        next_cycle(); dcache_stall = 1'b1;
        expect_out(21, 1, 1, 0, 0, 0, 32'h0, 2'd0, 32'hFFFF_FFFF, 32'd0);
        next_cycle(); dcache_stall = 1'b1;
        expect_out(22, 1, 1, 0, 0, 0, 32'h0, 2'd0, 32'hFFFF_FFFF, 32'd0);
        next_cycle();
        expect_out(23, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'hFFFF_FFFF, 32'd0);

        // Reset while pending discards the redirect.
        next_cycle(); ex_valid = 1'b1; ex_jump = 1'b1; ex_target = 32'h5C0; icache_stall = 1'b1;
        expect_out(24, 0, 0, 0, 1, 0, 32'h0, 2'd0, 32'hFFFF_FFFF, 32'd0);
        next_cycle(); icache_stall = 1'b1;
        expect_out(25, 0, 0, 0, 1, 0, 32'h0, 2'd1, 32'hFFFF_FFFF, 32'd1);
        next_cycle(); rst = 1'b1;
        expect_out(26, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'hFFFF_FFFF, 32'd1);
        next_cycle();
        expect_out(27, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd0, 32'd0);
        next_cycle();
        expect_out(28, 0, 0, 0, 0, 0, 32'h0, 2'd0, 32'd0, 32'd0);

        next_cycle();
        next_cycle();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single pipeline clock, all state on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
REQ-005 SHALL have ports ex_valid, ex_memrd  in  1 each, and ex_rd  in  5  for the EX instruction: valid, is load, destination.
REQ-006 SHALL have ports ex_jump, ex_branch_valid, ex_mispredict  in  1 each  EX-stage jal/jalr, branch resolved, prediction wrong.
REQ-007 SHALL have port ex_target  in  32  EX-computed redirect PC.
REQ-008 SHALL have ports dcache_stall, icache_stall  in  1 each  memory busy.
REQ-009 SHALL have port cnt_clr  in  1  synchronous counter clear.
REQ-010 SHALL have outputs stall_back (1), stall_front (1), bubble_ex (1), flush_front (1), redirect_valid (1), redirect_pc (32), state (2), stall_cnt (32), flush_cnt (32).
- stall_back drives the EX-stage stall.
- stall_front holds the IF/ID register.
- bubble_ex forces a NOP into ID/EX.
- flush_front kills IF/ID and ID/EX.

Function
REQ-011 SHALL define load_use = ex_valid & ex_memrd & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-012 SHALL define redir_evt = ex_valid & !dcache_stall & (ex_jump | (ex_branch_valid & ex_mispredict)).
REQ-013 SHALL implement a 2-state FSM: RUN=0, PEND=1; the state output carries the encoding.
REQ-014 SHALL drive all control outputs combinationally from the current state and inputs, with zero-cycle latency.
REQ-015 SHALL assert stall_back = dcache_stall in every state.
REQ-016 SHALL apply priority dcache_stall > redir_evt > load_use in RUN.
REQ-017 In RUN with dcache_stall, SHALL assert stall_front=1 and bubble_ex=0, and SHALL stay in RUN.
REQ-018 In RUN with redir_evt and !icache_stall, SHALL assert flush_front=1, redirect_valid=1, redirect_pc=ex_target, and SHALL stay in RUN.
REQ-019 In RUN with redir_evt and icache_stall, SHALL assert flush_front=1, redirect_valid=0, latch ex_target into pend_pc, and go to PEND.
REQ-020 In RUN with load_use (no higher-priority event), SHALL assert stall_front=1 and bubble_ex=1 for that cycle only; a load followed by a dependent instruction costs exactly one bubble.
REQ-021 In PEND, SHALL assert flush_front=1 every cycle and redirect_pc=pend_pc.
REQ-022 In PEND, SHALL assert redirect_valid = !icache_stall, and SHALL return to RUN on the cycle redirect_valid=1.
REQ-023 In PEND, SHALL ignore redir_evt and load_use; dcache_stall still drives stall_back and stall_front.
REQ-024 SHALL hold redirect_pc at 0 whenever redirect_valid=0.
REQ-025 SHALL increment stall_cnt on every cycle stall_front=1, saturating at 0xFFFFFFFF.
REQ-026 SHALL increment flush_cnt once per redir_evt accepted in RUN, not per PEND cycle, saturating at 0xFFFFFFFF.
REQ-027 SHALL give cnt_clr priority over increment: both counters read 0 on the next cycle.

Reset
REQ-028 While rst=1, SHALL force all control outputs to 0.
REQ-029 On a clock edge with rst=1, SHALL set state=RUN and clear pend_pc, stall_cnt and flush_cnt to 0.
REQ-030 Reset asserted in PEND SHALL discard the pending redirect; no redirect_valid is issued afterwards.

Structure
REQ-031 SHALL place the state encoding (RUN/PEND) and the counter width constant in the shared pipeline package.
REQ-032 SHALL implement both counters with one saturating-counter sub-module, sat_cnt32, instantiated twice.

Verification
REQ-033 Load-use: ex_memrd=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall_front=1 and bubble_ex=1 for one cycle; stall_cnt=1.
REQ-034 x0 load: same as REQ-033 with ex_rd=0 -> no stall and no bubble.
REQ-035 Mispredict, icache idle: ex_branch_valid=1, ex_mispredict=1, ex_target=0x100 -> same cycle flush_front=1, redirect_valid=1, redirect_pc=0x100; flush_cnt=1.
REQ-036 Jump, icache busy 3 cycles: ex_jump=1, ex_target=0x2A4 -> state PEND for 3 cycles with redirect_valid=0, then redirect_valid=1 with redirect_pc=0x2A4, then RUN; flush_cnt=1.
REQ-037 Simultaneous dcache_stall, mispredict and load_use -> stall_back=1, stall_front=1, no flush, no redirect; the event is honoured after the stall drops.
REQ-038 Saturation and reset: preload stall_cnt=0xFFFFFFFE, hold stall 3 cycles -> reads 0xFFFFFFFF; assert rst in PEND -> state=RUN, no redirect issued.
